accel_mem_responder: RTL
========================

# accel_mem_responder

Memory-side responder for the accelerator low-level memory bus: it answers req/addr/we/be/wdata transactions from the AXI-to-mem bridge or a bench initiator. It decodes control registers, status registers and a local data SRAM, and runs a small increment engine over the SRAM on command. It sits behind the AXI slave adapter inside the accelerator top and is the unit the accelerator testbench initiator talks to.

## Interface
- INT_ADDR_WIDTH, 20, word address width of the internal bus
- DATA_WIDTH, 32, bus and SRAM word width
- CTRL_WORDS, 4, number of control registers at addresses 0..CTRL_WORDS-1
- STAT_WORDS, 4, number of status registers at addresses CTRL_WORDS..CTRL_WORDS+STAT_WORDS-1
- MEM_DEPTH, 256, data SRAM depth in words; power of two

Ports:
- clk_s  in  1  clock, rising edge
- rst_n_s  in  1  reset, asynchronous, active-low
- mem_req_i  in  1  transaction request; always accepted, no grant
- mem_addr_i  in  INT_ADDR_WIDTH  word address
- mem_we_i  in  1  1 = write, 0 = read
- mem_be_i  in  DATA_WIDTH/8  byte enables, writes only
- mem_wdata_i  in  DATA_WIDTH  write data
- mem_rdata_o  out  DATA_WIDTH  read data, registered
- busy_o  out  1  engine running
- done_o  out  1  sticky completion flag

## Operation
- Decode: mem_addr_i[INT_ADDR_WIDTH-1]=1 selects SRAM, index = mem_addr_i[log2(MEM_DEPTH)-1:0]; else control, status, or unmapped region.
- Unmapped: reads return 0, writes dropped.
- Control word 0, byte-enable masked:
  - bit0 start, self-clearing, always reads 0
  - [15:8] max_cnt
  - [23:16] increment
- Control words 1..CTRL_WORDS-1 are plain R/W scratch registers.
- Status words are read-only; writes are dropped.
  - word 0: bit0 busy, bit1 done, bit2 conflict
  - word 1: words processed so far, zero-extended
  - word 2: cycle count (see Configuration)
  - word 3: constant 32'h4143_4331
- Engine FSM:
  - IDLE -> RD on start write. If max_cnt = 0, IDLE -> FIN directly.
  - RD: SRAM read of index i.
  - WR: write mem[i] + increment, modulo 2^DATA_WIDTH, increment zero-extended. Then i++. If i = max_cnt go to FIN, else RD.
  - FIN: set done, clear busy -> IDLE.
- Index i wraps modulo MEM_DEPTH when max_cnt > MEM_DEPTH.
- A start write sets max_cnt/increment, clears done, conflict, processed count and cycle count, and sets busy.
- Start write while busy: the whole control-word-0 write is ignored.
- Bus SRAM access while busy: engine owns the SRAM, writes are dropped, reads return 0, conflict is set (sticky).
- Reset mid-run: FSM to IDLE. All registers and outputs clear. SRAM contents undefined.

## Timing
- Reset values: mem_rdata_o=0, busy_o=0, done_o=0, all control/status registers 0 except word 3 constant.
- Read latency: 1 cycle. Request in cycle t gives mem_rdata_o valid in t+1 and held until the next read request. Back-to-back reads are allowed every cycle.
- Writes take effect at the clock edge of the request cycle; a read of the same address in t+1 returns the new value.
- Start written in cycle t: busy_o=1 from t+1.
- Engine takes 2 cycles per word; N words take 2N cycles.
- done_o=1 and busy_o=0 from cycle t+2N+2. For max_cnt=0, done_o=1 at t+2.
- done_o holds until the next accepted start.
- Same-cycle bus read of status word 0 and engine state change: the read returns the pre-edge value.

## Configuration
- ACCEL_RESP_CYCLE_CNT_EN defined: status word 2 is a 32-bit counter.
  - Cleared on start; increments every cycle while busy_o=1; saturates at all-ones.
- Undefined: no counter logic is built and status word 2 reads 0.

## Test plan
- Write SRAM[0..63] with bytes {4k+3,4k+2,4k+1,4k}, then write ctrl0=32'h0001_4001 (max_cnt=64, inc=1) -> done_o rises 130 cycles after the write; SRAM[k] reads old+1; status1=64; status0=32'h2.
- Read ctrl0..3 and status0..3 back-to-back -> data appears one cycle after each request; ctrl0 start bit reads 0; status3=32'h4143_4331.
- Partial write be=4'b0010 with wdata=32'hFFFF_20FF to ctrl0 -> only max_cnt=32'h20 changes; no start occurs.
- SRAM write to index 5 during a run -> write dropped, conflict bit set, status0 bit2=1; the next start clears it.
- ctrl0 write with max_cnt=0 -> done_o at +2 cycles, SRAM untouched. Second start while busy -> ignored, run completes with the original count.
- Assert rst_n_s low mid-run -> busy_o=0, done_o=0, mem_rdata_o=0 immediately. With the macro defined, status2 reads 2N+1 after a normal N-word run.

Source files
------------

// File: rtl/accel_mem_responder.sv
// rtl/accel_mem_responder.sv - memory-bus responder: control/status registers, data SRAM, increment engine
// Optional busy-cycle counter on status word 2 is built when ACCEL_RESP_CYCLE_CNT_EN is defined.
module accel_mem_responder #(
  parameter int INT_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_WORDS     = 4,
  parameter int STAT_WORDS     = 4,
  parameter int MEM_DEPTH      = 256
) (
  input  logic                      clk_s,
  input  logic                      rst_n_s,
  input  logic                      mem_req_i,
  input  logic [INT_ADDR_WIDTH-1:0] mem_addr_i,
  input  logic                      mem_we_i,
  input  logic [DATA_WIDTH/8-1:0]   mem_be_i,
  input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
  output logic [DATA_WIDTH-1:0]     mem_rdata_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CW_W  = (CTRL_WORDS > 1) ? $clog2(CTRL_WORDS) : 1;
  localparam logic [INT_ADDR_WIDTH-1:0] STAT_BASE  = INT_ADDR_WIDTH'(CTRL_WORDS);
  localparam logic [INT_ADDR_WIDTH-1:0] UNMAP_BASE = INT_ADDR_WIDTH'(CTRL_WORDS + STAT_WORDS);
  localparam logic [DATA_WIDTH-1:0]     ID_WORD    = DATA_WIDTH'(32'h4143_4331);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ctrl_scr [CTRL_WORDS];

  logic [7:0]            max_cnt_q, inc_q, run_max_q, run_inc_q;
  logic [DATA_WIDTH-1:0] proc_q, eng_data_q, cyc_cnt;
  logic                  busy_q, done_q, conflict_q;

  logic                      sel_sram, sel_ctrl, sel_stat, bus_wr, bus_rd, sram_hit;
  logic [IDX_W-1:0]          sram_idx, eng_idx;
  logic [CW_W-1:0]           ctrl_idx;
  logic [INT_ADDR_WIDTH-1:0] stat_off;
  logic [DATA_WIDTH-1:0]     be_mask, ctrl0_view, stat_rdata;
  logic [7:0]                new_max, new_inc;
  logic                      ctrl0_wr, start_req, start_go, ctrl0_take, last_word;
  logic                      eng_rd, eng_wr, eng_fin;

  assign busy_o = busy_q;
  assign done_o = done_q;

  assign bus_wr   = mem_req_i & mem_we_i;
  assign bus_rd   = mem_req_i & ~mem_we_i;
  assign sel_sram = mem_addr_i[INT_ADDR_WIDTH-1];
  assign sel_ctrl = ~sel_sram && (mem_addr_i < STAT_BASE);
  assign sel_stat = ~sel_sram && ~sel_ctrl && (mem_addr_i < UNMAP_BASE);
  assign sram_hit = mem_req_i & sel_sram;
  assign sram_idx = mem_addr_i[IDX_W-1:0];
  assign ctrl_idx = mem_addr_i[CW_W-1:0];
  assign stat_off = mem_addr_i - STAT_BASE;
  assign eng_idx  = proc_q[IDX_W-1:0];

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BE_W; b++) be_mask[8*b +: 8] = {8{mem_be_i[b]}};
  end

  // Control word 0 holds only max_cnt and increment; the start bit is never stored.
  assign ctrl0_view = DATA_WIDTH'({inc_q, max_cnt_q, 8'h00});
  assign new_max    = mem_be_i[1] ? mem_wdata_i[15:8]  : max_cnt_q;
  assign new_inc    = mem_be_i[2] ? mem_wdata_i[23:16] : inc_q;
  assign ctrl0_wr   = bus_wr && sel_ctrl && (ctrl_idx == '0);
  assign start_req  = ctrl0_wr && mem_be_i[0] && mem_wdata_i[0];
  assign start_go   = start_req && !busy_q;
  assign ctrl0_take = ctrl0_wr && !(start_req && busy_q);
  assign last_word  = (proc_q + DATA_WIDTH'(1)) == DATA_WIDTH'(run_max_q);

  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_go) state_d = (new_max == 8'd0) ? S_FIN : S_RD;
      S_RD:    state_d = S_WR;
      S_WR:    state_d = last_word ? S_FIN : S_RD;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eng_rd  = (state_q == S_RD);
    eng_wr  = (state_q == S_WR);
    eng_fin = (state_q == S_FIN);
  end

  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      max_cnt_q  <= '0;
      inc_q      <= '0;
      run_max_q  <= '0;
      run_inc_q  <= '0;
      proc_q     <= '0;
      eng_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
      for (int w = 0; w < CTRL_WORDS; w++) ctrl_scr[w] <= '0;
    end else begin
      if (ctrl0_take) begin
        max_cnt_q <= new_max;
        inc_q     <= new_inc;
      end
      for (int w = 1; w < CTRL_WORDS; w++)
        if (bus_wr && sel_ctrl && (ctrl_idx == CW_W'(w)))
          ctrl_scr[w] <= (ctrl_scr[w] & ~be_mask) | (mem_wdata_i & be_mask);
      if (eng_rd) eng_data_q <= mem[eng_idx];
      if (start_go) begin
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        conflict_q <= 1'b0;
        proc_q     <= '0;
        run_max_q  <= new_max;
        run_inc_q  <= new_inc;
      end else begin
        if (eng_wr) proc_q <= proc_q + DATA_WIDTH'(1);
        if (eng_fin) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        if (sram_hit && busy_q) conflict_q <= 1'b1;
      end
    end
  end

  // The engine owns the SRAM while busy, so bus and engine writes never coincide.
  always_ff @(posedge clk_s) begin
    if (eng_wr) begin
      mem[eng_idx] <= eng_data_q + DATA_WIDTH'(run_inc_q);
    end else if (bus_wr && sel_sram && !busy_q) begin
      for (int b = 0; b < BE_W; b++)
        if (mem_be_i[b]) mem[sram_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
    end
  end

`ifdef ACCEL_RESP_CYCLE_CNT_EN
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s)                    cyc_cnt <= '0;
    else if (start_go)               cyc_cnt <= '0;
    else if (busy_q && cyc_cnt != '1) cyc_cnt <= cyc_cnt + DATA_WIDTH'(1);
  end
`else
  assign cyc_cnt = '0;
`endif

  always_comb begin
    stat_rdata = '0;
    case (stat_off)
      INT_ADDR_WIDTH'(0): stat_rdata = DATA_WIDTH'({conflict_q, done_q, busy_q});
      INT_ADDR_WIDTH'(1): stat_rdata = proc_q;
      INT_ADDR_WIDTH'(2): stat_rdata = cyc_cnt;
      INT_ADDR_WIDTH'(3): stat_rdata = ID_WORD;
      default:            stat_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      mem_rdata_o <= '0;
    end else if (bus_rd) begin
      if (sel_sram)      mem_rdata_o <= busy_q ? '0 : mem[sram_idx];
      else if (sel_ctrl) mem_rdata_o <= (ctrl_idx == '0) ? ctrl0_view : ctrl_scr[ctrl_idx];
      else if (sel_stat) mem_rdata_o <= stat_rdata;
      else               mem_rdata_o <= '0;
    end
  end

endmodule
